// File: rtl/mem_burst_defs.sv
// Shared definitions for the cache/memory burst protocol: widths, responder FSM states,
// and the response-delay LFSR constants.
package mem_burst_defs;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STRB_W = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11, right-shifting Fibonacci form (taps at bits 0, 2, 3, 5)
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_FETCH,
    S_RD_RSP,
    S_WR_DATA
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port 32-bit word RAM: synchronous registered read, per-byte write enable.
module mem_word_ram #(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter string       INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      rd_en,
  input  logic [3:0]                wr_be,
  input  logic [MEM_WORDS_LOG2-1:0] addr,
  input  logic [31:0]               wr_data,
  output logic [31:0]               rd_data
);

  localparam int unsigned Depth = 1 << MEM_WORDS_LOG2;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side burst responder serving cache read/write bursts from an on-chip word RAM.
// Define MEM_RSP_DELAY_EN to insert LFSR-driven stalls on read beats and write beats.
module burst_mem_responder
  import mem_burst_defs::*;
#(
  parameter int unsigned MEM_WORDS_LOG2 = 12,
  parameter string       INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              from_cache_rd_req_valid,
  input  logic [ADDR_W-1:0] from_cache_rd_req_addr,
  input  logic [LEN_W-1:0]  from_cache_rd_req_len,
  output logic              to_cache_rd_req_ready,

  output logic              to_cache_rd_rsp_valid,
  output logic [DATA_W-1:0] to_cache_rd_rsp_data,
  output logic              to_cache_rd_rsp_last,
  input  logic              from_cache_rd_rsp_ready,

  input  logic              from_cache_wr_req_valid,
  input  logic [ADDR_W-1:0] from_cache_wr_req_addr,
  input  logic [LEN_W-1:0]  from_cache_wr_req_len,
  output logic              to_cache_wr_req_ready,

  input  logic              from_cache_wr_data_valid,
  input  logic [DATA_W-1:0] from_cache_wr_data,
  input  logic [STRB_W-1:0] from_cache_wr_data_strb,
  input  logic              from_cache_wr_data_last,
  output logic              to_cache_wr_data_ready,

  output logic              to_dbg_proto_err
);

  localparam int unsigned PW = MEM_WORDS_LOG2;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  // Keeps request readies low from reset assertion until the first clock after release.
  logic            run_q;

  logic            ram_rd_en;
  logic [3:0]      ram_be;
  logic            rsp_gate;
  logic            wr_gate;
  logic            at_last;

  // Word pointer takes addr[PW+1:2]; byte offset and bits above the RAM are dropped.
  logic unused_addr;
  assign unused_addr = ^{from_cache_rd_req_addr[ADDR_W-1:PW+2], from_cache_rd_req_addr[1:0],
                         from_cache_wr_req_addr[ADDR_W-1:PW+2], from_cache_wr_req_addr[1:0]};

`ifdef MEM_RSP_DELAY_EN
  logic [15:0] lfsr_q;
  logic        held_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
      held_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      held_q <= to_cache_rd_rsp_valid & ~from_cache_rd_rsp_ready;
    end
  end

  // A raised read beat stays up until taken; stalls only delay raising it.
  assign rsp_gate = lfsr_q[0] | held_q;
  assign wr_gate  = lfsr_q[0];
`else
  assign rsp_gate = 1'b1;
  assign wr_gate  = 1'b1;
`endif

  assign at_last          = (cnt_q == len_q);
  assign to_dbg_proto_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    to_cache_rd_req_ready  = 1'b0;
    to_cache_wr_req_ready  = 1'b0;
    to_cache_rd_rsp_valid  = 1'b0;
    to_cache_rd_rsp_last   = 1'b0;
    to_cache_wr_data_ready = 1'b0;
    ram_rd_en              = 1'b0;
    ram_be                 = '0;

    unique case (state_q)
      S_IDLE: begin
        // Write wins a same-cycle tie so a dirty write-back drains before the refill.
        to_cache_wr_req_ready = run_q;
        to_cache_rd_req_ready = run_q & ~from_cache_wr_req_valid;
        if (from_cache_wr_req_valid && to_cache_wr_req_ready) begin
          ptr_d   = from_cache_wr_req_addr[PW+1:2];
          len_d   = from_cache_wr_req_len;
          cnt_d   = '0;
          state_d = S_WR_DATA;
        end else if (from_cache_rd_req_valid && to_cache_rd_req_ready) begin
          ptr_d   = from_cache_rd_req_addr[PW+1:2];
          len_d   = from_cache_rd_req_len;
          cnt_d   = '0;
          state_d = S_RD_FETCH;
        end
      end

      S_RD_FETCH: begin
        ram_rd_en = 1'b1;
        state_d   = S_RD_RSP;
      end

      S_RD_RSP: begin
        to_cache_rd_rsp_valid = rsp_gate;
        to_cache_rd_rsp_last  = at_last;
        if (to_cache_rd_rsp_valid && from_cache_rd_rsp_ready) begin
          if (at_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            ptr_d   = ptr_q + PW'(1);
            state_d = S_RD_FETCH;
          end
        end
      end

      S_WR_DATA: begin
        to_cache_wr_data_ready = wr_gate;
        if (from_cache_wr_data_valid && to_cache_wr_data_ready) begin
          ram_be = from_cache_wr_data_strb;
          // Beat count alone ends the burst; a disagreeing last is only reported.
          if (from_cache_wr_data_last != at_last) begin
            err_d = 1'b1;
          end
          if (at_last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            ptr_d = ptr_q + PW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  mem_word_ram #(
    .MEM_WORDS_LOG2 (MEM_WORDS_LOG2),
    .INIT_FILE      (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .wr_be   (ram_be),
    .addr    (ptr_q),
    .wr_data (from_cache_wr_data),
    .rd_data (to_cache_rd_rsp_data)
  );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Randomized self-checking bench for burst_mem_responder against a word-array memory model.
module tb_burst_mem_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        from_cache_rd_req_valid;
  logic [31:0] from_cache_rd_req_addr;
  logic [7:0]  from_cache_rd_req_len;
  logic        to_cache_rd_req_ready;
  logic        to_cache_rd_rsp_valid;
  logic [31:0] to_cache_rd_rsp_data;
  logic        to_cache_rd_rsp_last;
  logic        from_cache_rd_rsp_ready;
  logic        from_cache_wr_req_valid;
  logic [31:0] from_cache_wr_req_addr;
  logic [7:0]  from_cache_wr_req_len;
  logic        to_cache_wr_req_ready;
  logic        from_cache_wr_data_valid;
  logic [31:0] from_cache_wr_data;
  logic [3:0]  from_cache_wr_data_strb;
  logic        from_cache_wr_data_last;
  logic        to_cache_wr_data_ready;
  logic        to_dbg_proto_err;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .MEM_WORDS_LOG2 (AW),
    .INIT_FILE      ("")
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_cache_rd_req_valid  (from_cache_rd_req_valid),
    .from_cache_rd_req_addr   (from_cache_rd_req_addr),
    .from_cache_rd_req_len    (from_cache_rd_req_len),
    .to_cache_rd_req_ready    (to_cache_rd_req_ready),
    .to_cache_rd_rsp_valid    (to_cache_rd_rsp_valid),
    .to_cache_rd_rsp_data     (to_cache_rd_rsp_data),
    .to_cache_rd_rsp_last     (to_cache_rd_rsp_last),
    .from_cache_rd_rsp_ready  (from_cache_rd_rsp_ready),
    .from_cache_wr_req_valid  (from_cache_wr_req_valid),
    .from_cache_wr_req_addr   (from_cache_wr_req_addr),
    .from_cache_wr_req_len    (from_cache_wr_req_len),
    .to_cache_wr_req_ready    (to_cache_wr_req_ready),
    .from_cache_wr_data_valid (from_cache_wr_data_valid),
    .from_cache_wr_data       (from_cache_wr_data),
    .from_cache_wr_data_strb  (from_cache_wr_data_strb),
    .from_cache_wr_data_last  (from_cache_wr_data_last),
    .to_cache_wr_data_ready   (to_cache_wr_data_ready),
    .to_dbg_proto_err         (to_dbg_proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wbuf  [DEPTH];
  logic [3:0]  sbuf  [DEPTH];
  logic [31:0] rdat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the final beat.
  task automatic do_write(input logic [31:0] addr, input int len, input int early_last);
    int cyc;
    int ptr;
    int stalls;
    from_cache_wr_req_valid = 1'b1;
    from_cache_wr_req_addr  = addr;
    from_cache_wr_req_len   = 8'(len);
    cyc = 0;
    while (!to_cache_wr_req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_req_accept", 32'(to_cache_wr_req_ready), 32'd1);
    @(negedge clk);
    from_cache_wr_req_valid = 1'b0;
    ptr    = int'(addr[AW+1:2]);
    stalls = 0;
    for (int b = 0; b <= len; b++) begin
      from_cache_wr_data       = wbuf[b];
      from_cache_wr_data_strb  = sbuf[b];
      from_cache_wr_data_last  = (b == len) || (b == early_last);
      from_cache_wr_data_valid = 1'b1;
      cyc = 0;
      while (!to_cache_wr_data_ready && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      stalls += cyc;
      if (!to_cache_wr_data_ready) begin
        check("wr_beat_accept", 32'(to_cache_wr_data_ready), 32'd1);
        break;
      end
      for (int i = 0; i < 4; i++) begin
        if (sbuf[b][i]) model[(ptr + b) % DEPTH][8*i +: 8] = wbuf[b][8*i +: 8];
      end
      @(negedge clk);
    end
    from_cache_wr_data_valid = 1'b0;
    from_cache_wr_data_last  = 1'b0;
    check("wr_done_idle", 32'(to_cache_wr_req_ready), 32'd1);
    check("wr_no_extra_ready", 32'(to_cache_wr_data_ready), 32'd0);
`ifndef MEM_RSP_DELAY_EN
    check("wr_stall_cycles", 32'(stalls), 32'd0);
`endif
  endtask

  // Called at a negedge. bp_beat gets bp_len cycles of rsp_ready low; abort_beat returns
  // as soon as that beat is visible, without taking it.
  task automatic do_read(input logic [31:0] addr, input int len, input int bp_beat,
                         input int bp_len, input int abort_beat, output logic [31:0] got_last);
    int cyc;
    int ptr;
    logic [31:0] exp;
    got_last = 'x;
    from_cache_rd_req_valid = 1'b1;
    from_cache_rd_req_addr  = addr;
    from_cache_rd_req_len   = 8'(len);
    from_cache_rd_rsp_ready = 1'b1;
    cyc = 0;
    while (!to_cache_rd_req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_req_accept", 32'(to_cache_rd_req_ready), 32'd1);
    @(negedge clk);
    from_cache_rd_req_valid = 1'b0;
    ptr = int'(addr[AW+1:2]);
    for (int b = 0; b <= len; b++) begin
      cyc = 0;
      while (!to_cache_rd_rsp_valid && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (!to_cache_rd_rsp_valid) begin
        check("rd_beat_valid", 32'(to_cache_rd_rsp_valid), 32'd1);
        return;
      end
`ifndef MEM_RSP_DELAY_EN
      check("rd_beat_latency", 32'(cyc), 32'd1);
`endif
      if (b == abort_beat) return;
      exp = model[(ptr + b) % DEPTH];
      if (b == bp_beat) begin
        from_cache_rd_rsp_ready = 1'b0;
        for (int k = 0; k < bp_len; k++) begin
          @(negedge clk);
          check("bp_valid_hold", 32'(to_cache_rd_rsp_valid), 32'd1);
          check("bp_data_hold", to_cache_rd_rsp_data, exp);
          check("bp_last_hold", 32'(to_cache_rd_rsp_last), 32'(b == len));
        end
        from_cache_rd_rsp_ready = 1'b1;
      end
      check("rd_data", to_cache_rd_rsp_data, exp);
      check("rd_last", 32'(to_cache_rd_rsp_last), 32'(b == len));
      got_last = to_cache_rd_rsp_data;
      @(negedge clk);
    end
    check("rd_no_extra_beat", 32'(to_cache_rd_rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    from_cache_rd_req_valid  = 1'b0;
    from_cache_rd_req_addr   = '0;
    from_cache_rd_req_len    = '0;
    from_cache_rd_rsp_ready  = 1'b1;
    from_cache_wr_req_valid  = 1'b0;
    from_cache_wr_req_addr   = '0;
    from_cache_wr_req_len    = '0;
    from_cache_wr_data_valid = 1'b0;
    from_cache_wr_data       = '0;
    from_cache_wr_data_strb  = '0;
    from_cache_wr_data_last  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rd_req_ready", 32'(to_cache_rd_req_ready), 32'd0);
    check("rst_wr_req_ready", 32'(to_cache_wr_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(to_cache_rd_rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(to_cache_rd_rsp_last), 32'd0);
    check("rst_wr_data_ready", 32'(to_cache_wr_data_ready), 32'd0);
    check("rst_proto_err", 32'(to_dbg_proto_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_wr_req_ready", 32'(to_cache_wr_req_ready), 32'd1);
    check("idle_rd_req_ready", 32'(to_cache_rd_req_ready), 32'd1);

    // Make the whole RAM known to the model.
    for (int i = 0; i < DEPTH; i++) begin
      wbuf[i] = $urandom;
      sbuf[i] = 4'hF;
    end
    do_write(32'h0, DEPTH - 1, -1);

    // Read burst from words 0x40..0x47.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    do_write(32'h100, 7, -1);
    do_read(32'h100, 7, -1, 0, -1, rdat);
    check("rd_burst_final", rdat, 32'h1007);

    // Single-beat strobed write merges into the old word.
    wbuf[0] = 32'hAABBCCDD;
    sbuf[0] = 4'hF;
    do_write(32'h200, 0, -1);
    wbuf[0] = 32'h11223344;
    sbuf[0] = 4'b0011;
    do_write(32'h200, 0, -1);
    do_read(32'h200, 0, -1, 0, -1, rdat);
    check("strobe_merge", rdat, 32'hAABB3344);
    wbuf[0] = 32'hDEADBEEF;
    sbuf[0] = 4'b0000;
    do_write(32'h200, 0, -1);
    do_read(32'h200, 0, -1, 0, -1, rdat);
    check("strobe_none", rdat, 32'hAABB3344);

    // Write-back then read of the same lines.
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 32'hD0 + 32'(i);
      sbuf[i] = 4'hF;
    end
    do_write(32'h300, 7, -1);
    do_read(32'h300, 7, -1, 0, -1, rdat);
    check("wb_read_final", rdat, 32'hD7);

    // Early last on beat 5: error flagged, burst still 8 beats.
    check("err_before", 32'(to_dbg_proto_err), 32'd0);
    do_write(32'h300, 7, 4);
    check("err_early_last", 32'(to_dbg_proto_err), 32'd1);

    // Same-cycle read and write requests: write first.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hE0 + 32'(i);
    from_cache_rd_req_valid = 1'b1;
    from_cache_rd_req_addr  = 32'h300;
    from_cache_rd_req_len   = 8'd7;
    from_cache_wr_req_valid = 1'b1;
    #1;
    check("simul_rd_ready", 32'(to_cache_rd_req_ready), 32'd0);
    check("simul_wr_ready", 32'(to_cache_wr_req_ready), 32'd1);
    do_write(32'h300, 7, -1);
    check("simul_rd_ready_after", 32'(to_cache_rd_req_ready), 32'd1);
    do_read(32'h300, 7, -1, 0, -1, rdat);
    check("simul_rd_final", rdat, 32'hE7);

    // Backpressure for 3 cycles on beat 2.
    do_read(32'h100, 7, 1, 3, -1, rdat);

    // Pointer wrap, with high address bits and byte offset ignored.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(32'h3F8, 3, -1);
    do_read(32'hFFFF_F3FB, 3, -1, 0, -1, rdat);
    check("wrap_final", rdat, wbuf[3]);

    // Reset mid-burst at beat 3 of 8.
    do_read(32'h100, 7, -1, 0, 2, rdat);
    check("pre_rst_valid", 32'(to_cache_rd_rsp_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(to_cache_rd_rsp_valid), 32'd0);
    check("mid_rst_last", 32'(to_cache_rd_rsp_last), 32'd0);
    check("mid_rst_rd_req_ready", 32'(to_cache_rd_req_ready), 32'd0);
    check("mid_rst_wr_req_ready", 32'(to_cache_wr_req_ready), 32'd0);
    check("mid_rst_proto_err", 32'(to_dbg_proto_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(to_cache_rd_rsp_valid), 32'd0);
    check("post_rst_rd_req_ready", 32'(to_cache_rd_req_ready), 32'd1);
    do_read(32'h100, 7, -1, 0, -1, rdat);
    check("post_rst_final", rdat, 32'h1007);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] a;
      int          l;
      a = $urandom;
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= l; i++) begin
          wbuf[i] = $urandom;
          sbuf[i] = 4'($urandom);
        end
        do_write(a, l, -1);
      end else begin
        do_read(a, l, ($urandom_range(0, 1) == 1) ? $urandom_range(0, l) : -1,
                $urandom_range(1, 4), -1, rdat);
      end
    end
    check("rand_proto_err", 32'(to_dbg_proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
